ascii_case_stream: RTL and testbench

//  Streaming ASCII case-conversion stage with valid/ready flow control.

---
 rtl/ascii_case_stream.sv | 153 +++++++++++++++
 tb/tb_ascii_case_stream.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascii_case_stream.sv
// Streaming ASCII case converter with a 2-entry output queue and a word-position FSM
// that drives title-case conversion.
//
// state | meaning
// WS    | word start: next letter is the first of a word
// IW    | in word: inside a run of non-separator bytes
`timescale 1ns/1ps
module ascii_case_stream #(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic [1:0]         mode,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [7:0]         in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [7:0]         out_data,
    output logic [COUNT_W-1:0] conv_count
);

    typedef enum logic [1:0] {
        MODE_PASS  = 2'b00,
        MODE_UPPER = 2'b01,
        MODE_LOWER = 2'b10,
        MODE_TITLE = 2'b11
    } conv_mode_t;

    typedef enum logic {
        WS = 1'b0,
        IW = 1'b1
    } word_state_t;

    word_state_t state;
    word_state_t state_nx;

    logic [7:0] q0;
    logic [7:0] q1;
    logic [1:0] occ;

    logic       accept;
    logic       pop;
    logic       is_upper;
    logic       is_lower;
    logic       is_letter;
    logic       is_sep;
    logic [7:0] conv_data;
    logic       changed;
    conv_mode_t mode_sel;

    // Handshake depends only on registered occupancy, so out_ready never reaches in_ready.
    assign in_ready  = (occ < 2'd2);
    assign out_valid = (occ != 2'd0);
    assign out_data  = q0;
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign is_upper  = (in_data >= 8'h41) && (in_data <= 8'h5A);
    assign is_lower  = (in_data >= 8'h61) && (in_data <= 8'h7A);
    assign is_letter = is_upper | is_lower;
    assign is_sep    = (in_data == 8'h20) || (in_data == 8'h09) ||
                       (in_data == 8'h0A) || (in_data == 8'h0D);
    assign mode_sel  = conv_mode_t'(mode);

    // Letter case lives entirely in bit5; non-letters pass through untouched.
    always_comb begin
        conv_data = in_data;
        if (is_letter) begin
            unique case (mode_sel)
                MODE_PASS:  conv_data[5] = in_data[5];
                MODE_UPPER: conv_data[5] = 1'b0;
                MODE_LOWER: conv_data[5] = 1'b1;
                MODE_TITLE: conv_data[5] = (state == IW);
                default:    conv_data[5] = in_data[5];
            endcase
        end
    end

    assign changed = (conv_data != in_data);

    always_comb begin
        state_nx = state;
        if (accept) begin
            unique case (state)
                WS:      state_nx = is_sep ? WS : IW;
                IW:      state_nx = is_sep ? WS : IW;
                default: state_nx = WS;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= WS;
        end else if (clear) begin
            state <= WS;
        end else begin
            state <= state_nx;
        end
    end

    // q0 is always the head; a pop while full shifts q1 forward.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q0  <= 8'h00;
            q1  <= 8'h00;
            occ <= 2'd0;
        end else if (clear) begin
            q0  <= 8'h00;
            q1  <= 8'h00;
            occ <= 2'd0;
        end else begin
            unique case (occ)
                2'd0: begin
                    if (accept) begin
                        q0  <= conv_data;
                        occ <= 2'd1;
                    end
                end
                2'd1: begin
                    if (accept && pop) begin
                        q0 <= conv_data;
                    end else if (accept) begin
                        q1  <= conv_data;
                        occ <= 2'd2;
                    end else if (pop) begin
                        occ <= 2'd0;
                    end
                end
                2'd2: begin
                    if (pop) begin
                        q0  <= q1;
                        occ <= 2'd1;
                    end
                end
                default: occ <= 2'd0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conv_count <= '0;
        end else if (clear) begin
            conv_count <= '0;
        end else if (accept && changed && (conv_count != {COUNT_W{1'b1}})) begin
            conv_count <= conv_count + {{(COUNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_ascii_case_stream.sv
// Self-checking bench for ascii_case_stream: directed vector table, hand sequences for
// back-pressure/clear/reset, and randomized traffic against a queue-based reference model.
`timescale 1ns/1ps
module tb_ascii_case_stream;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic [1:0]  mode;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [15:0] conv_count;
    logic        in_ready4;
    logic        out_valid4;
    logic [7:0]  out_data4;
    logic [3:0]  conv_count4;

    int checks = 0;
    int failures = 0;

    ascii_case_stream #(.COUNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .conv_count(conv_count)
    );

    ascii_case_stream #(.COUNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
        .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
        .conv_count(conv_count4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [7:0] mq[$];
    bit         m_ws = 1'b1;
    int         m_cnt = 0;
    int         m_cnt4 = 0;
    int         n_acc = 0;
    bit         stalled_prev = 1'b0;
    logic [7:0] held = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit ref_is_sep(input logic [7:0] c);
        return (c == 8'd32) || (c == 8'd9) || (c == 8'd10) || (c == 8'd13);
    endfunction

    function automatic logic [7:0] ref_conv(input logic [7:0] c, input logic [1:0] m, input bit ws);
        int v;
        bit up;
        bit lo;
        v  = int'(c);
        up = (v >= 65) && (v <= 90);
        lo = (v >= 97) && (v <= 122);
        case (m)
            2'd1: if (lo) v = v - 32;
            2'd2: if (up) v = v + 32;
            2'd3: begin
                if (ws && lo) v = v - 32;
                else if (!ws && up) v = v + 32;
            end
            default: ;
        endcase
        return 8'(v);
    endfunction

    task automatic model_reset();
        mq.delete();
        m_ws = 1'b1;
        m_cnt = 0;
        m_cnt4 = 0;
        stalled_prev = 1'b0;
    endtask

    task automatic monitor_step();
        bit acc;
        bit pop;
        logic [7:0] c;
        if (!rst_n) begin
            model_reset();
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_data", out_data, 8'h00);
            chk("rst_in_ready", in_ready, 1);
            chk("rst_conv_count", conv_count, 0);
            return;
        end
        chk("in_ready", in_ready, mq.size() < 2);
        chk("out_valid", out_valid, mq.size() != 0);
        chk("in_ready4", in_ready4, mq.size() < 2);
        chk("out_valid4", out_valid4, mq.size() != 0);
        if (mq.size() != 0) begin
            chk("out_data", out_data, mq[0]);
            chk("out_data4", out_data4, mq[0]);
        end
        if (stalled_prev) chk("stall_hold", out_data, held);
        chk("conv_count", conv_count, m_cnt);
        chk("conv_count4", conv_count4, m_cnt4);
        stalled_prev = 1'b0;
        if (clear) begin
            mq.delete();
            m_ws = 1'b1;
            m_cnt = 0;
            m_cnt4 = 0;
            return;
        end
        pop = (mq.size() != 0) && out_ready;
        acc = in_valid && (mq.size() < 2);
        c = 8'h00;
        if (acc) begin
            c = ref_conv(in_data, mode, m_ws);
            m_ws = ref_is_sep(in_data);
            if (c != in_data) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt4 < 15) m_cnt4++;
            end
            n_acc++;
        end
        if (pop) void'(mq.pop_front());
        if (acc) mq.push_back(c);
        if (!pop && mq.size() != 0) begin
            stalled_prev = 1'b1;
            held = mq[0];
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        monitor_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        in_valid = 1'b0;
        clear = 1'b1;
        cycle();
        clear = 1'b0;
    endtask

    typedef struct {
        bit         clr;
        logic [1:0] mode;
        logic [7:0] din;
        logic [7:0] dout;
        int         cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add_byte(input bit clr, input logic [1:0] m, input logic [7:0] di,
                            input logic [7:0] d_o, input int cnt);
        vec_t v;
        v.clr = clr; v.mode = m; v.din = di; v.dout = d_o; v.cnt = cnt;
        vecs.push_back(v);
    endtask

    task automatic add_grp(input bit clr, input logic [1:0] m, input string si,
                           input string so, input int cnt);
        for (int i = 0; i < si.len(); i++)
            add_byte(clr && (i == 0), m, si[i], so[i], (i == si.len() - 1) ? cnt : -1);
    endtask

    function automatic logic [7:0] rand_byte();
        logic [7:0] sep[4];
        sep[0] = 8'h20; sep[1] = 8'h09; sep[2] = 8'h0A; sep[3] = 8'h0D;
        case ($urandom_range(0, 3))
            0:       return 8'(8'h61 + $urandom_range(0, 25));
            1:       return 8'(8'h41 + $urandom_range(0, 25));
            2:       return sep[$urandom_range(0, 3)];
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    initial begin
        int base;
        int cyc;
        rst_n = 1'b0; clear = 1'b0; mode = 2'd0; in_valid = 1'b0;
        out_ready = 1'b0; in_data = 8'h00;

        repeat (3) cycle();
        rst_n = 1'b1;
        cycle();

        // Directed conversion table
        add_grp(1, 2'd1, "abZ{", "ABZ{", 2);
        add_grp(1, 2'd3, "hELLO wORLD\n", "Hello World\n", 10);
        add_grp(0, 2'd3, "x", "X", 11);
        add_byte(1, 2'd2, 8'hC1, 8'hC1, -1);
        add_byte(0, 2'd2, 8'h40, 8'h40, -1);
        add_byte(0, 2'd2, 8'h5B, 8'h5B, -1);
        add_byte(0, 2'd2, 8'h60, 8'h60, -1);
        add_byte(0, 2'd2, 8'h7B, 8'h7B, 0);
        add_grp(1, 2'd0, "aZ9", "aZ9", 0);

        out_ready = 1'b1;
        foreach (vecs[i]) begin
            if (vecs[i].clr) do_clear();
            in_valid = 1'b1;
            mode = vecs[i].mode;
            in_data = vecs[i].din;
            cycle();
            chk("vec_out_valid", out_valid, 1);
            chk($sformatf("vec%0d_data", i), out_data, vecs[i].dout);
            if (vecs[i].cnt >= 0) chk("vec_count", conv_count, vecs[i].cnt);
        end
        in_valid = 1'b0;
        cycle();
        chk("drain_empty", out_valid, 0);

        // Back-pressure: fill, block third byte, then drain in order
        do_clear();
        mode = 2'd0; out_ready = 1'b0; in_valid = 1'b1;
        in_data = 8'h31; chk("bp_rdy0", in_ready, 1); cycle();
        in_data = 8'h32; chk("bp_rdy1", in_ready, 1); cycle();
        in_data = 8'h33; chk("bp_full", in_ready, 0); cycle();
        chk("bp_full_hold", in_ready, 0);
        chk("bp_head", out_data, 8'h31);
        out_ready = 1'b1; cycle();
        chk("bp_pop1_data", out_data, 8'h32);
        chk("bp_pop1_rdy", in_ready, 1);
        cycle();
        chk("bp_pop2_data", out_data, 8'h33);
        chk("bp_pop2_valid", out_valid, 1);
        in_valid = 1'b0; cycle();
        chk("bp_empty", out_valid, 0);

        // Clear with two bytes queued and a byte offered
        mode = 2'd1; out_ready = 1'b0; in_valid = 1'b1;
        in_data = 8'h61; cycle();
        in_data = 8'h62; cycle();
        chk("clr_pre_count", conv_count, 2);
        clear = 1'b1; in_data = 8'h63; cycle();
        clear = 1'b0; in_valid = 1'b0;
        chk("clr_valid", out_valid, 0);
        chk("clr_count", conv_count, 0);
        chk("clr_rdy", in_ready, 1);
        cycle();
        chk("clr_dropped", out_valid, 0);

        // Asynchronous reset mid-stream
        in_valid = 1'b1; in_data = 8'h71; cycle();
        in_data = 8'h72; cycle();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_data", out_data, 8'h00);
        chk("arst_rdy", in_ready, 1);
        chk("arst_count", conv_count, 0);
        cycle();
        rst_n = 1'b1;
        cycle();
        chk("arst_after", out_valid, 0);

        // Counter saturation on the narrow instance
        do_clear();
        mode = 2'd1; out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_data = 8'(8'h61 + (i % 26));
            cycle();
        end
        in_valid = 1'b0;
        chk("sat_count16", conv_count, 20);
        chk("sat_count4", conv_count4, 15);
        cycle();

        // Random traffic, upper mode, 10k accepted bytes
        do_clear();
        mode = 2'd1;
        base = n_acc;
        cyc = 0;
        while ((n_acc - base) < 10000 && cyc < 60000) begin
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_data = rand_byte();
            cycle();
            cyc++;
        end
        chk("rand_budget", ((n_acc - base) >= 10000) ? 32'd1 : 32'd0, 1);

        // Random traffic with mode changes and occasional clear
        for (int i = 0; i < 3000; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_data = rand_byte();
            mode = 2'($urandom_range(0, 3));
            clear = ($urandom_range(0, 299) == 0);
            cycle();
        end
        clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) cycle();
        chk("final_empty", out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
